au_scheduler: RTL and testbench
===============================

# au_scheduler

Sequencing and arbitration controller for the shared 4-bit `arithmetic_unit`. Two requesters each present a three-operand bundle (X2, X1, X0) with a valid/ready handshake. The block grants the unit round-robin, registers the operands, and drives the unit for a fixed settle window. It then captures F and returns it on a single response channel tagged with the requester ID.

## Interface
- `EXEC_CYCLES`, default 1: cycles the operands are held on the unit before F is captured; legal range 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  bit i: requester i presents an operation.
- `req_ready`  out  2  bit i: requester i's operation is accepted this cycle.
- `req0_x2`, `req0_x1`, `req0_x0`  in  4 each  requester 0 operands.
- `req1_x2`, `req1_x1`, `req1_x0`  in  4 each  requester 1 operands.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `resp_data`  out  4  captured F.
- `resp_id`  out  1  requester that issued the operation.
- `busy`  out  1  high in EXEC or RESP.

## Operation
- Contains one `arithmetic_unit` instance, which is combinational in X2/X1/X0 -> F.
- The unit's inputs come only from the internal operand registers.
- FSM states:
  - IDLE: no operation in flight.
  - EXEC: operands held on the unit; settle counter running.
  - RESP: result presented, waiting for the consumer.
- IDLE:
  - Arbitration runs each cycle.
  - `req_ready[i]` = IDLE & grant[i]; at most one bit is high.
  - On acceptance: latch the granted bundle into the operand registers, latch the ID, load the counter with EXEC_CYCLES-1, go to EXEC.
- Arbitration is round-robin with a `last` pointer:
  - Only one valid: that requester is granted.
  - Both valid: the requester != `last` is granted.
  - `last` updates to the granted ID on acceptance only.
  - Reset value of `last` is 1, so requester 0 wins the first tie.
- EXEC:
  - Counter decrements each cycle.
  - On the cycle the counter is 0: capture F into `resp_data` and go to RESP.
- RESP:
  - `resp_valid`=1, and `resp_data`/`resp_id` are stable.
  - On `resp_valid & resp_ready`: go to IDLE.
  - Stays in RESP indefinitely while `resp_ready`=0.
- Requests arriving outside IDLE see `req_ready`=0 and must hold. There is no queueing beyond the single operand slot.
- Operand register changes during EXEC or RESP are impossible by construction.

## Timing
- Reset values: state IDLE; `req_ready`=00; `resp_valid`=0; `resp_data`=0000; `resp_id`=0; `busy`=0; operand registers 0; counter 0; `last`=1.
- Reset asserted mid-operation: the in-flight operation is dropped, no response is produced, and all of the above values apply immediately (asynchronous).
- `req_ready` is combinational from state and `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Latency, with acceptance at edge T:
  - EXEC occupies cycles T+1 .. T+EXEC_CYCLES.
  - `resp_valid` rises after edge T+EXEC_CYCLES.
  - With EXEC_CYCLES=1: response visible 2 cycles after acceptance.
- Minimum issue interval with `resp_ready` held high: EXEC_CYCLES + 2 cycles.
  - The response handshake cycle returns the FSM to IDLE.
  - The next acceptance can occur in the following cycle.
  - No accept occurs in the same cycle as the response handshake.
- `busy` is a registered decode of state (EXEC or RESP).

## Test plan
- Reset, idle: hold `rst_n`=0, then release with all valids low -> all outputs at their reset values; `req_ready`=00 for ≥5 cycles.
- Single request, EXEC_CYCLES=1: req0 X2=1100, X1=0011, X0=0100 -> `req_ready`=01 in the same cycle; `resp_valid` 2 cycles later with `resp_data`=0111, `resp_id`=0.
- Tie and round-robin: both valid continuously with distinct operands, `resp_ready`=1 -> grants alternate 0,1,0,1; `resp_id` sequence 0,1,0,1; each `resp_data` equals the unit's F for that bundle.
- Backpressure: `resp_ready`=0 for 6 cycles after `resp_valid` rises -> `resp_valid`, `resp_data` and `resp_id` stay stable; `req_ready`=00 throughout; single response on release.
- Settle window: EXEC_CYCLES=4 with a single request -> `resp_valid` exactly 5 cycles after acceptance; `busy` high from the cycle after acceptance until the response handshake.
- Reset mid-EXEC: assert `rst_n`=0 during EXEC -> `resp_valid` never asserts for that operation; after release, a tie is granted to requester 0.

Source files
------------

// File: rtl/au_scheduler.sv
// Round-robin sequencer for the shared 4-bit arithmetic unit: grants one of two
// requesters, holds its operands on the unit for a settle window, returns F tagged with the ID.

module arithmetic_unit (
  input  logic [3:0] x2,
  input  logic [3:0] x1,
  input  logic [3:0] x0,
  output logic [3:0] f
);
  // x2[0] selects subtract (x1 - x0) versus add (x1 + x0), modulo 16
  assign f = x2[0] ? (x1 - x0) : (x1 + x0);
endmodule

module au_scheduler #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req0_x2,
  input  logic [3:0] req0_x1,
  input  logic [3:0] req0_x0,
  input  logic [3:0] req1_x2,
  input  logic [3:0] req1_x1,
  input  logic [3:0] req1_x0,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [3:0] resp_data,
  output logic       resp_id,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] x2_q, x2_d, x1_q, x1_d, x0_q, x0_d;
  logic       id_q, id_d;
  logic       last_q, last_d;
  logic [3:0] resp_data_q, resp_data_d;
  logic       busy_q, busy_d;
  logic [1:0] grant;
  logic [3:0] unit_f;

  arithmetic_unit u_unit (
    .x2 (x2_q),
    .x1 (x1_q),
    .x0 (x0_q),
    .f  (unit_f)
  );

  // On a tie the requester that did not win last time is granted
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = (state_q == IDLE) ? grant : 2'b00;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x2_d        = x2_q;
    x1_d        = x1_q;
    x0_d        = x0_q;
    id_d        = id_q;
    last_d      = last_q;
    resp_data_d = resp_data_q;
    case (state_q)
      IDLE: begin
        if (req_ready != 2'b00) begin
          id_d    = req_ready[1];
          last_d  = req_ready[1];
          x2_d    = req_ready[1] ? req1_x2 : req0_x2;
          x1_d    = req_ready[1] ? req1_x1 : req0_x1;
          x0_d    = req_ready[1] ? req1_x0 : req0_x0;
          cnt_d   = CNT_LOAD;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          resp_data_d = unit_f;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      x2_q        <= 4'd0;
      x1_q        <= 4'd0;
      x0_q        <= 4'd0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      resp_data_q <= 4'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x2_q        <= x2_d;
      x1_q        <= x1_d;
      x0_q        <= x0_d;
      id_q        <= id_d;
      last_q      <= last_d;
      resp_data_q <= resp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_id    = id_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_au_scheduler.sv
// Directed bench for au_scheduler: instance A uses a one-cycle settle window,
// instance B a four-cycle window; expected values are hand-computed.

module tb_au_scheduler;

  logic       clk;
  logic       rst_n;

  logic [1:0] a_req_valid, a_req_ready;
  logic [11:0] a_op0, a_op1;
  logic       a_resp_valid, a_resp_ready, a_resp_id, a_busy;
  logic [3:0] a_resp_data;

  logic [1:0] b_req_valid, b_req_ready;
  logic [11:0] b_op0, b_op1;
  logic       b_resp_valid, b_resp_ready, b_resp_id, b_busy;
  logic [3:0] b_resp_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Operand bundles {x2,x1,x0} and their F (x2[0] ? x1-x0 : x1+x0, mod 16)
  logic [11:0] bund [4];
  logic [3:0]  bf   [4];

  au_scheduler #(.EXEC_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req0_x2(a_op0[11:8]), .req0_x1(a_op0[7:4]), .req0_x0(a_op0[3:0]),
    .req1_x2(a_op1[11:8]), .req1_x1(a_op1[7:4]), .req1_x0(a_op1[3:0]),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_data(a_resp_data), .resp_id(a_resp_id), .busy(a_busy)
  );

  au_scheduler #(.EXEC_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req0_x2(b_op0[11:8]), .req0_x1(b_op0[7:4]), .req0_x0(b_op0[3:0]),
    .req1_x2(b_op1[11:8]), .req1_x1(b_op1[7:4]), .req1_x0(b_op1[3:0]),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_data(b_resp_data), .resp_id(b_resp_id), .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [11:0] op0,
                               input logic [11:0] op1, input logic rr);
    a_req_valid  = valid;
    a_op0        = op0;
    a_op1        = op1;
    a_resp_ready = rr;
    #1;
  endtask

  initial begin
    int n;
    logic [11:0] cur0, cur1;
    logic [1:0]  exp_grant;
    int          nxt0, nxt1, idx;
    int          exp_idx [4];

    bund[0] = {4'b0000, 4'b0101, 4'b0110}; bf[0] = 4'b1011;
    bund[1] = {4'b0001, 4'b1001, 4'b0011}; bf[1] = 4'b0110;
    bund[2] = {4'b0010, 4'b1111, 4'b0010}; bf[2] = 4'b0001;
    bund[3] = {4'b0011, 4'b0010, 4'b0101}; bf[3] = 4'b1101;

    rst_n = 1'b0;
    a_req_valid = 2'b00; a_op0 = '0; a_op1 = '0; a_resp_ready = 1'b0;
    b_req_valid = 2'b00; b_op0 = '0; b_op1 = '0; b_resp_ready = 1'b0;

    // Reset values, then idle with no requests
    #1;
    checkOutput("rst_req_ready", 32'(a_req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    checkOutput("rst_resp_data", 32'(a_resp_data), 32'd0);
    checkOutput("rst_resp_id", 32'(a_resp_id), 32'd0);
    checkOutput("rst_busy", 32'(a_busy), 32'd0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("idle_req_ready", 32'(a_req_ready), 32'd0);
      checkOutput("idle_resp_valid", 32'(a_resp_valid), 32'd0);
    end

    // Single request from requester 0: 3 + 4 = 7
    applyStimulus(2'b01, {4'b1100, 4'b0011, 4'b0100}, 12'd0, 1'b1);
    checkOutput("single_ready", 32'(a_req_ready), 32'b01);
    tick();
    checkOutput("single_busy", 32'(a_busy), 32'd1);
    checkOutput("single_early", 32'(a_resp_valid), 32'd0);
    applyStimulus(2'b00, 12'd0, 12'd0, 1'b1);
    tick();
    checkOutput("single_valid", 32'(a_resp_valid), 32'd1);
    checkOutput("single_data", 32'(a_resp_data), 32'b0111);
    checkOutput("single_id", 32'(a_resp_id), 32'd0);
    tick();
    checkOutput("single_done", 32'(a_resp_valid), 32'd0);
    checkOutput("single_idle_busy", 32'(a_busy), 32'd0);

    // Pulse reset so the first tie below goes to requester 0
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // Both requesters valid continuously: grants alternate 0,1,0,1
    exp_idx[0] = 0; exp_idx[1] = 1; exp_idx[2] = 2; exp_idx[3] = 3;
    cur0 = bund[0]; cur1 = bund[1]; nxt0 = 2; nxt1 = 3;
    applyStimulus(2'b11, cur0, cur1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (a_req_ready == 2'b00 && n < 10) begin
        tick();
        n++;
      end
      if (k > 0) checkOutput("rr_issue_gap", 32'(n), 32'd1);
      exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
      checkOutput("rr_grant", 32'(a_req_ready), 32'(exp_grant));
      tick();
      if (exp_grant == 2'b01) begin
        cur0 = (nxt0 < 4) ? bund[nxt0] : bund[0];
        nxt0 += 2;
      end else begin
        cur1 = (nxt1 < 4) ? bund[nxt1] : bund[1];
        nxt1 += 2;
      end
      applyStimulus((k == 3) ? 2'b00 : 2'b11, cur0, cur1, 1'b1);
      checkOutput("rr_exec_ready", 32'(a_req_ready), 32'd0);
      n = 0;
      while (a_resp_valid !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      checkOutput("rr_latency", 32'(n), 32'd1);
      idx = exp_idx[k];
      checkOutput("rr_resp_id", 32'(a_resp_id), 32'(k % 2));
      checkOutput("rr_resp_data", 32'(a_resp_data), 32'(bf[idx]));
    end
    tick();
    checkOutput("rr_drain", 32'(a_resp_valid), 32'd0);

    // Backpressure: requester 1 alone, 4 - 7 = 13; requester 0 waits meanwhile
    applyStimulus(2'b10, 12'd0, {4'b0001, 4'b0100, 4'b0111}, 1'b0);
    checkOutput("bp_grant", 32'(a_req_ready), 32'b10);
    tick();
    applyStimulus(2'b01, bund[0], 12'd0, 1'b0);
    tick();
    checkOutput("bp_valid", 32'(a_resp_valid), 32'd1);
    checkOutput("bp_data", 32'(a_resp_data), 32'b1101);
    checkOutput("bp_id", 32'(a_resp_id), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("bp_hold_valid", 32'(a_resp_valid), 32'd1);
      checkOutput("bp_hold_data", 32'(a_resp_data), 32'b1101);
      checkOutput("bp_hold_id", 32'(a_resp_id), 32'd1);
      checkOutput("bp_hold_ready", 32'(a_req_ready), 32'd0);
    end
    applyStimulus(2'b01, bund[0], 12'd0, 1'b1);
    checkOutput("bp_release_ready", 32'(a_req_ready), 32'd0);
    tick();
    applyStimulus(2'b00, 12'd0, 12'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_single_resp", 32'(a_resp_valid), 32'd0);
      tick();
    end

    // Reset during EXEC drops the operation; tie afterwards goes to requester 0
    applyStimulus(2'b01, bund[2], 12'd0, 1'b1);
    checkOutput("mid_grant", 32'(a_req_ready), 32'b01);
    tick();
    applyStimulus(2'b00, 12'd0, 12'd0, 1'b1);
    checkOutput("mid_busy", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(a_busy), 32'd0);
    checkOutput("mid_rst_data", 32'(a_resp_data), 32'd0);
    checkOutput("mid_rst_valid", 32'(a_resp_valid), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("mid_no_resp", 32'(a_resp_valid), 32'd0);
    end
    applyStimulus(2'b11, bund[0], bund[1], 1'b1);
    checkOutput("mid_tie_grant", 32'(a_req_ready), 32'b01);
    applyStimulus(2'b00, 12'd0, 12'd0, 1'b1);

    // Four-cycle settle window on instance B: 9 - 3 = 6
    b_req_valid = 2'b01; b_op0 = bund[1]; b_resp_ready = 1'b0;
    #1;
    checkOutput("settle_grant", 32'(b_req_ready), 32'b01);
    tick();
    b_req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      checkOutput("settle_busy", 32'(b_busy), 32'd1);
      checkOutput("settle_wait", 32'(b_resp_valid), 32'd0);
      if (i < 3) tick();
    end
    tick();
    checkOutput("settle_valid", 32'(b_resp_valid), 32'd1);
    checkOutput("settle_data", 32'(b_resp_data), 32'b0110);
    checkOutput("settle_id", 32'(b_resp_id), 32'd0);
    checkOutput("settle_busy_resp", 32'(b_busy), 32'd1);
    b_resp_ready = 1'b1;
    tick();
    checkOutput("settle_done", 32'(b_resp_valid), 32'd0);
    checkOutput("settle_idle_busy", 32'(b_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
